// File: rtl/bram_param.sv
// -----------------------------------------------------------------------------
// bram_param
// Single-port block RAM behind a fixed-latency request/ready handshake.
// One access (read or write) is accepted from IDLE. The memory itself is
// touched only on the acceptance edge: a write commits there, and the prior
// word is read out in the same edge (read-before-write). The block then waits
// LATENCY cycles and presents the captured word on a registered output
// together with a one-cycle ready pulse.
//
// Optional feature macro: BRAM_PARAM_BYTEMASK_EN
//   defined   -> 'be' byte-enable port exists; only enabled bytes are written
//   undefined -> no 'be' port; writes are always full-word
// -----------------------------------------------------------------------------
module bram_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 11,
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              startReadRAM,
`ifdef BRAM_PARAM_BYTEMASK_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic [DATA_W-1:0] out,
  output logic              readRdyRAM,
  output logic              saveRdyRAM,
  output logic              busy,
  output logic              err
);

  // Wait counter is wide enough to hold LATENCY-1 without wrapping.
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  // Memory index width; a one-word memory still needs a 1-bit index.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH widened by one bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    RD_DONE = 3'd3,
    WR_DONE = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_oob;
  logic [DATA_W-1:0]  r_out;
  logic [DATA_W-1:0]  r_rd_word;

  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept_rd;
  logic               w_accept_wr;
  logic               w_accept;
  logic               w_load_out;
  logic               w_mem_en;
  logic               w_mem_we;

  // Zero at power-up; reset deliberately leaves the contents alone.
  logic [DATA_W-1:0]  r_mem [DEPTH] = '{default: '0};

  assign w_in_range = ({1'b0, addr} < DEPTH_L);
  assign w_idx      = addr[IDX_W-1:0];
  assign w_accept   = w_accept_rd | w_accept_wr;

  // The memory port is gated by rst so a request held during reset can
  // neither write nor disturb the captured word.
  assign w_mem_en   = w_accept & rst;
  assign w_mem_we   = w_accept_wr & w_in_range & rst;

  // Next-state, counter and handshake decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept_rd  = 1'b0;
    w_accept_wr  = 1'b0;
    w_load_out   = 1'b0;
    readRdyRAM   = 1'b0;
    saveRdyRAM   = 1'b0;
    busy         = 1'b1;
    err          = 1'b0;

    case (r_state)
      IDLE: begin
        busy = 1'b0;
        // Read has priority; a simultaneous write request is dropped.
        if (startReadRAM) begin
          w_state_next = RD_WAIT;
          w_cnt_next   = '0;
          w_accept_rd  = 1'b1;
        end else if (we) begin
          w_state_next = WR_WAIT;
          w_cnt_next   = '0;
          w_accept_wr  = 1'b1;
        end
      end

      RD_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = RD_DONE;
          w_load_out   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      WR_WAIT: begin
        if (r_cnt == LAST_CNT) begin
          w_state_next = WR_DONE;
          w_load_out   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      RD_DONE: begin
        readRdyRAM   = 1'b1;
        err          = r_oob;
        w_state_next = IDLE;
      end

      WR_DONE: begin
        saveRdyRAM   = 1'b1;
        err          = r_oob;
        w_state_next = IDLE;
      end

      default: begin
        busy         = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Control registers: state, wait counter, range flag and result word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_oob   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_oob <= ~w_in_range;
      end
      // An out-of-range access always reports a zero word.
      if (w_load_out) begin
        r_out <= r_oob ? '0 : r_rd_word;
      end
    end
  end

  assign out = r_out;

  // Registered read port; sees the pre-write word on a write acceptance.
  always_ff @(posedge clk) begin
    if (w_mem_en) begin
      r_rd_word <= r_mem[w_idx];
    end
  end

`ifdef BRAM_PARAM_BYTEMASK_EN
  localparam int LANES = DATA_W / 8;

  logic [LANES-1:0] w_lane_we;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane_we[gi] = w_mem_we & be[gi];
    end
  endgenerate

  // Byte-lane write port; lanes with be cleared keep their old contents.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (w_lane_we[b]) begin
        r_mem[w_idx][b*8 +: 8] <= din[b*8 +: 8];
      end
    end
  end
`else
  // Full-word write port.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= din;
    end
  end
`endif

endmodule

// File: tb/tb_bram_param.sv
// -----------------------------------------------------------------------------
// tb_bram_param
// Two instances: A uses the default geometry (LATENCY=64), B uses DEPTH=1000,
// LATENCY=1 for range and back-to-back checks. Every accepted access pushes
// its expected completion onto a per-instance queue; a negedge monitor pops
// and compares whenever a ready pulse appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_param;

  localparam int LAT_A = 64;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A signals
  logic [10:0] addr_a;
  logic [31:0] din_a;
  logic        we_a, rd_a;
  logic [31:0] out_a;
  logic        rrdy_a, srdy_a, busy_a, err_a;
  // Instance B signals
  logic [10:0] addr_b;
  logic [31:0] din_b;
  logic        we_b, rd_b;
  logic [31:0] out_b;
  logic        rrdy_b, srdy_b, busy_b, err_b;
`ifdef BRAM_PARAM_BYTEMASK_EN
  logic [3:0]  be_a, be_b;
`endif

  bram_param u_dut_a (
    .clk(clk), .rst(rst), .addr(addr_a), .din(din_a), .we(we_a),
    .startReadRAM(rd_a),
`ifdef BRAM_PARAM_BYTEMASK_EN
    .be(be_a),
`endif
    .out(out_a), .readRdyRAM(rrdy_a), .saveRdyRAM(srdy_a),
    .busy(busy_a), .err(err_a)
  );

  bram_param #(.DATA_W(32), .ADDR_W(11), .DEPTH(1000), .LATENCY(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst), .addr(addr_b), .din(din_b), .we(we_b),
    .startReadRAM(rd_b),
`ifdef BRAM_PARAM_BYTEMASK_EN
    .be(be_b),
`endif
    .out(out_b), .readRdyRAM(rrdy_b), .saveRdyRAM(srdy_b),
    .busy(busy_b), .err(err_b)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] exp_out;
    logic        exp_err;
    int          exp_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
  endtask

  // Completion monitor, instance A
  always @(negedge clk) begin
    exp_t e;
    if (rrdy_a || srdy_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_ready", {30'd0, rrdy_a, srdy_a}, 32'd0);
      end else begin
        e = q_a.pop_front();
        $display("A done %s out=0x%08h err=%0b cyc=%0d", rrdy_a ? "rd" : "wr", out_a, err_a, cyc);
        chk("a_ready_kind", {31'd0, rrdy_a}, {31'd0, e.is_rd});
        chk("a_ready_excl", {31'd0, rrdy_a & srdy_a}, 32'd0);
        chk("a_out", out_a, e.exp_out);
        chk("a_err", {31'd0, err_a}, {31'd0, e.exp_err});
        chk("a_latency", cyc, e.exp_cyc);
      end
    end else begin
      chk("a_err_outside_done", {31'd0, err_a}, 32'd0);
    end
  end

  // Completion monitor, instance B
  always @(negedge clk) begin
    exp_t e;
    if (rrdy_b || srdy_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_ready", {30'd0, rrdy_b, srdy_b}, 32'd0);
      end else begin
        e = q_b.pop_front();
        $display("B done %s out=0x%08h err=%0b cyc=%0d", rrdy_b ? "rd" : "wr", out_b, err_b, cyc);
        chk("b_ready_kind", {31'd0, rrdy_b}, {31'd0, e.is_rd});
        chk("b_ready_excl", {31'd0, rrdy_b & srdy_b}, 32'd0);
        chk("b_out", out_b, e.exp_out);
        chk("b_err", {31'd0, err_b}, {31'd0, e.exp_err});
        chk("b_latency", cyc, e.exp_cyc);
      end
    end else begin
      chk("b_err_outside_done", {31'd0, err_b}, 32'd0);
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_a_out",  out_a, 32'd0);
    chk("rst_a_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_a_rrdy", {31'd0, rrdy_a}, 32'd0);
    chk("rst_a_srdy", {31'd0, srdy_a}, 32'd0);
    chk("rst_a_err",  {31'd0, err_a}, 32'd0);
    chk("rst_b_out",  out_b, 32'd0);
    chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
    chk("rst_b_rrdy", {31'd0, rrdy_b}, 32'd0);
    chk("rst_b_srdy", {31'd0, srdy_b}, 32'd0);
    chk("rst_b_err",  {31'd0, err_b}, 32'd0);
  endtask

  // Called at a negedge; request is accepted on the following posedge.
  task automatic acc_a(input logic rd, input logic wr, input logic [10:0] a,
                       input logic [31:0] d, input logic [31:0] exp_out, input logic exp_err);
    exp_t e;
    bit   got;
    got = 1'b0;
    addr_a = a; din_a = d; rd_a = rd; we_a = wr;
    e.is_rd = rd; e.exp_out = exp_out; e.exp_err = exp_err; e.exp_cyc = cyc + 1 + LAT_A;
    q_a.push_back(e);
    $display("A req rd=%0b wr=%0b addr=%0d din=0x%08h", rd, wr, a, d);
    @(negedge clk);
    rd_a = 1'b0; we_a = 1'b0;
    chk("a_busy_after_accept", {31'd0, busy_a}, 32'd1);
    for (int i = 0; i < LAT_A + 8 && !got; i++) begin
      if (rrdy_a || srdy_a) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      chk("a_busy_in_done", {31'd0, busy_a}, 32'd1);
    end else begin
      chk("a_ready_timeout", 32'd0, 32'd1);
      if (q_a.size() > 0) q_a.delete(0);
    end
  endtask

  task automatic acc_b(input logic rd, input logic wr, input logic [10:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_out, input logic exp_err);
    exp_t e;
    bit   got;
    got = 1'b0;
    addr_b = a; din_b = d; rd_b = rd; we_b = wr;
`ifdef BRAM_PARAM_BYTEMASK_EN
    be_b = be;
`endif
    e.is_rd = rd; e.exp_out = exp_out; e.exp_err = exp_err; e.exp_cyc = cyc + 1 + LAT_B;
    q_b.push_back(e);
    $display("B req rd=%0b wr=%0b addr=%0d din=0x%08h be=%b", rd, wr, a, d, be);
    @(negedge clk);
    rd_b = 1'b0; we_b = 1'b0;
    chk("b_busy_after_accept", {31'd0, busy_b}, 32'd1);
    for (int i = 0; i < LAT_B + 8 && !got; i++) begin
      if (rrdy_b || srdy_b) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk("b_ready_timeout", 32'd0, 32'd1);
      if (q_b.size() > 0) q_b.delete(0);
    end
  endtask

  initial begin
    int n_pulses;
    // {rd, wr, addr, din, be, expected out, expected err}
    vecs[0]  = '{1'b0, 1'b1, 11'd0,    32'h11111111, 4'hF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 11'd999,  32'h99999999, 4'hF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 11'd999,  32'h00000000, 4'hF, 32'h99999999, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 11'd1500, 32'h00000000, 4'hF, 32'h00000000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 11'd1000, 32'h55555555, 4'hF, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 11'd0,    32'h00000000, 4'hF, 32'h11111111, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 11'd0,    32'h22222222, 4'hF, 32'h11111111, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 11'd0,    32'h00000000, 4'hF, 32'h22222222, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 11'd0,    32'h33333333, 4'hF, 32'h22222222, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 11'd0,    32'h00000000, 4'hF, 32'h22222222, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 11'd2047, 32'h00000000, 4'hF, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 11'd999,  32'hA5A5A5A5, 4'hF, 32'h99999999, 1'b0};

    rst = 1'b0;
    addr_a = '0; din_a = '0; we_a = 1'b0; rd_a = 1'b0;
    addr_b = '0; din_b = '0; we_b = 1'b0; rd_b = 1'b0;
`ifdef BRAM_PARAM_BYTEMASK_EN
    be_a = 4'hF; be_b = 4'hF;
`endif
    repeat (3) @(negedge clk);
    chk_reset_outputs();

    // Release reset and request in the same cycle: first posedge accepts.
    rst = 1'b1;
    acc_a(1'b0, 1'b1, 11'd5, 32'hDEADBEEF, 32'h00000000, 1'b0);
    @(negedge clk);
    chk("a_idle_after_done", {31'd0, busy_a}, 32'd0);
    acc_a(1'b1, 1'b0, 11'd5, 32'h00000000, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("a_out_hold", out_a, 32'hDEADBEEF);
    end
    @(negedge clk);
    acc_a(1'b1, 1'b1, 11'd5, 32'h00000001, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    acc_a(1'b1, 1'b0, 11'd5, 32'h00000000, 32'hDEADBEEF, 1'b0);

    // Write to 7 is committed at acceptance, then reset aborts it mid-wait.
    @(negedge clk);
    addr_a = 11'd7; din_a = 32'hCAFEF00D; we_a = 1'b1;
    $display("A req rd=0 wr=1 addr=7 din=0xcafef00d (to be aborted)");
    @(negedge clk);
    we_a = 1'b0;
    for (int i = 1; i < 31; i++) begin
      rd_a = (i == 5);
      we_a = (i == 12);
      addr_a = 11'd5;
      din_a = 32'h00000000;
      @(negedge clk);
    end
    rd_a = 1'b0; we_a = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_pulses = 0;
    for (int i = 0; i < LAT_A + 10; i++) begin
      @(negedge clk);
      if (rrdy_a || srdy_a) n_pulses++;
    end
    chk("a_no_ready_after_abort", n_pulses, 32'd0);
    acc_a(1'b1, 1'b0, 11'd5, 32'h00000000, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    acc_a(1'b1, 1'b0, 11'd7, 32'h00000000, 32'hCAFEF00D, 1'b0);

    // Back-to-back table on B, each request in the first IDLE cycle after DONE.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      acc_b(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].be,
            vecs[i].exp_out, vecs[i].exp_err);
    end

`ifdef BRAM_PARAM_BYTEMASK_EN
    @(negedge clk);
    acc_b(1'b0, 1'b1, 11'd3, 32'hAABBCCDD, 4'b0101, 32'h00000000, 1'b0);
    @(negedge clk);
    acc_b(1'b1, 1'b0, 11'd3, 32'h00000000, 4'hF, 32'h00BB00DD, 1'b0);
    @(negedge clk);
    acc_b(1'b0, 1'b1, 11'd3, 32'hFFFFFFFF, 4'b0000, 32'h00BB00DD, 1'b0);
    @(negedge clk);
    acc_b(1'b1, 1'b0, 11'd3, 32'h00000000, 4'hF, 32'h00BB00DD, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("a_queue_drained", q_a.size(), 32'd0);
    chk("b_queue_drained", q_b.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
